// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btb_pkg
// Description : Shared BTB types and constants: update-queue entry layout,
//               PC step and BTB-facing field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package btb_pkg;

    localparam int          BTB_PC_W     = 32;
    localparam int          BTB_TAG_W    = 30;
    localparam int          BTB_TARGET_W = 32;
    localparam logic [31:0] BTB_PC_STEP  = 32'd4;

    typedef struct packed {
        logic [BTB_TAG_W-1:0]    pc;
        logic                    taken;
        logic [BTB_TARGET_W-1:0] target;
    } btb_upd_entry_t;

endpackage : btb_pkg
`default_nettype wire

// File: rtl/btb_upd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : btb_upd_fifo
// Description : Generic power-of-two FIFO with push/pop, full/empty flags.
//               Storage element type is a type parameter.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = btb_upd_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_push,
    input  ENTRY_T i_push_data,
    input  logic   i_pop,
    output ENTRY_T o_pop_data,
    output logic   o_full,
    output logic   o_empty
);

    localparam int               c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

    ENTRY_T               r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 w_push;
    logic                 w_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    assign o_full     = (r_count == c_depth);
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : btb_upd_fifo
`default_nettype wire

// File: rtl/btb_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : btb_update_queue
// Description : Buffers resolved branches and drains them in order into the
//               BTB update port; flags mispredictions with a registered
//               redirect. Optional saturating statistics: BTB_UPD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_update_queue
    import btb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic [31:0]     res_pc,
    input  logic            res_taken,
    input  logic [31:0]     res_target,
    input  logic            res_pred_taken,
    input  logic [31:0]     res_pred_target,
    input  logic            upd_hold,
    output logic            update_en,
    output logic [29:0]     update_pc,
    output logic            actual_taken,
    output logic [31:0]     update_target,
    output logic            mispredict_valid,
    output logic [31:0]     redirect_pc,
    output logic [CNTW-1:0] stat_updates,
    output logic [CNTW-1:0] stat_mispredicts
);

    btb_upd_entry_t w_push_entry;
    btb_upd_entry_t w_head_entry;
    logic           w_full;
    logic           w_empty;
    logic           w_accept;
    logic           w_pop;
    logic           w_mispredict;
    logic [31:0]    w_redirect;
    logic [1:0]     w_unused_pc_lsb;

    logic           r_update_en;
    logic [29:0]    r_update_pc;
    logic           r_actual_taken;
    logic [31:0]    r_update_target;
    logic           r_mispredict_valid;
    logic [31:0]    r_redirect_pc;

    // Branch PCs are word aligned; the low bits carry no information.
    assign w_unused_pc_lsb = res_pc[1:0];

    assign w_push_entry = '{pc: res_pc[31:2], taken: res_taken, target: res_target};

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign res_ready = ~w_full;
    assign w_accept  = res_valid & res_ready;
    assign w_pop     = ~w_empty & ~upd_hold;

    assign w_mispredict = (res_taken != res_pred_taken) |
                          (res_taken & (res_target != res_pred_target));
    assign w_redirect   = res_taken ? res_target : (res_pc + BTB_PC_STEP);

    btb_upd_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (btb_upd_entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_accept),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_pop_data  (w_head_entry),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_update_en     <= 1'b0;
            r_update_pc     <= '0;
            r_actual_taken  <= 1'b0;
            r_update_target <= '0;
        end else begin
            r_update_en <= w_pop;
            if (w_pop) begin
                r_update_pc     <= w_head_entry.pc;
                r_actual_taken  <= w_head_entry.taken;
                r_update_target <= w_head_entry.target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mispredict_valid <= 1'b0;
            r_redirect_pc      <= '0;
        end else begin
            r_mispredict_valid <= w_accept & w_mispredict;
            if (w_accept & w_mispredict) begin
                r_redirect_pc <= w_redirect;
            end
        end
    end

    assign update_en        = r_update_en;
    assign update_pc        = r_update_pc;
    assign actual_taken     = r_actual_taken;
    assign update_target    = r_update_target;
    assign mispredict_valid = r_mispredict_valid;
    assign redirect_pc      = r_redirect_pc;

`ifdef BTB_UPD_STATS_EN
    logic [CNTW-1:0] r_stat_updates;
    logic [CNTW-1:0] r_stat_mispredicts;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_updates     <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_pop && (r_stat_updates != '1)) begin
                r_stat_updates <= r_stat_updates + CNTW'(1);
            end
            if (w_accept && w_mispredict && (r_stat_mispredicts != '1)) begin
                r_stat_mispredicts <= r_stat_mispredicts + CNTW'(1);
            end
        end
    end

    assign stat_updates     = r_stat_updates;
    assign stat_mispredicts = r_stat_mispredicts;
`else
    assign stat_updates     = '0;
    assign stat_mispredicts = '0;
`endif

endmodule : btb_update_queue
`default_nettype wire

// File: tb/tb_btb_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_update_queue
// Description : Directed plus randomized bench for btb_update_queue against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_update_queue;

    localparam int DEPTH = 4;
    localparam int CNTW  = 4;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } res_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_pc;
    logic            res_taken;
    logic [31:0]     res_target;
    logic            res_pred_taken;
    logic [31:0]     res_pred_target;
    logic            upd_hold;
    logic            update_en;
    logic [29:0]     update_pc;
    logic            actual_taken;
    logic [31:0]     update_target;
    logic            mispredict_valid;
    logic [31:0]     redirect_pc;
    logic [CNTW-1:0] stat_updates;
    logic [CNTW-1:0] stat_mispredicts;

    btb_update_queue #(
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .res_pred_taken   (res_pred_taken),
        .res_pred_target  (res_pred_target),
        .upd_hold         (upd_hold),
        .update_en        (update_en),
        .update_pc        (update_pc),
        .actual_taken     (actual_taken),
        .update_target    (update_target),
        .mispredict_valid (mispredict_valid),
        .redirect_pc      (redirect_pc),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    // Reference model state
    res_t        m_q[$];
    logic        m_en;
    logic [31:0] m_pc;
    logic        m_taken;
    logic [31:0] m_target;
    logic        m_mis;
    logic [31:0] m_redirect;
    int          m_nupd;
    int          m_nmis;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int n);
        int mx;
        mx = (1 << CNTW) - 1;
`ifdef BTB_UPD_STATS_EN
        return 64'((n > mx) ? mx : n);
`else
        return 64'(0 * n);
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_en = 0; m_pc = 0; m_taken = 0; m_target = 0;
        m_mis = 0; m_redirect = 0; m_nupd = 0; m_nmis = 0;
    endtask

    task automatic check_all();
        chk("res_ready", 64'(res_ready), 64'(m_q.size() < DEPTH));
        chk("update_en", 64'(update_en), 64'(m_en));
        chk("update_pc", 64'(update_pc), 64'(m_pc[31:2]));
        chk("actual_taken", 64'(actual_taken), 64'(m_taken));
        chk("update_target", 64'(update_target), 64'(m_target));
        chk("mispredict_valid", 64'(mispredict_valid), 64'(m_mis));
        chk("redirect_pc", 64'(redirect_pc), 64'(m_redirect));
        chk("stat_updates", 64'(stat_updates), sat(m_nupd));
        chk("stat_mispredicts", 64'(stat_mispredicts), sat(m_nmis));
    endtask

    // One clock: drive at negedge, advance model, check just after posedge.
    task automatic cyc(input logic r, input logic v, input logic [31:0] pc,
                       input logic t, input logic [31:0] tg, input logic pt,
                       input logic [31:0] ptg, input logic h);
        bit   acc;
        bit   pop;
        bit   mis;
        res_t e;
        @(negedge clk);
        rst = r; res_valid = v; res_pc = pc; res_taken = t; res_target = tg;
        res_pred_taken = pt; res_pred_target = ptg; upd_hold = h;
        if (r) begin
            model_reset();
        end else begin
            acc = v && (m_q.size() < DEPTH);
            pop = (m_q.size() != 0) && !h;
            m_en = pop;
            if (pop) begin
                e = m_q.pop_front();
                m_pc = e.pc; m_taken = e.taken; m_target = e.target;
                m_nupd++;
            end
            mis = (t != pt) || (t && (tg != ptg));
            m_mis = acc && mis;
            if (acc) begin
                m_q.push_back('{pc, t, tg});
                if (mis) begin
                    m_redirect = t ? tg : pc + 32'd4;
                    m_nmis++;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input logic h);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, h);
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] tg;
        logic        t;
        rst = 1'b1; res_valid = 0; res_pc = 0; res_taken = 0; res_target = 0;
        res_pred_taken = 0; res_pred_target = 0; upd_hold = 0;
        model_reset();
        @(posedge clk);
        cyc(1'b1, 0, 0, 0, 0, 0, 0, 0);
        idle(1'b0);
        chk("reset_ready", 64'(res_ready), 64'd1);
        chk("reset_update_en", 64'(update_en), 64'd0);
        chk("reset_redirect", 64'(redirect_pc), 64'd0);

        // Correctly predicted taken branch
        cyc(0, 1, 32'h100, 1, 32'h200, 1, 32'h200, 0);
        chk("tp1_no_mis", 64'(mispredict_valid), 64'd0);
        idle(1'b0);
        chk("tp1_en", 64'(update_en), 64'd1);
        chk("tp1_pc", 64'(update_pc), 64'h40);
        chk("tp1_target", 64'(update_target), 64'h200);

        // Direction mispredict
        cyc(0, 1, 32'h104, 0, 32'h0, 1, 32'h0, 0);
        chk("tp2_mis", 64'(mispredict_valid), 64'd1);
        chk("tp2_redirect", 64'(redirect_pc), 64'h108);

        // Target mispredict
        cyc(0, 1, 32'h10, 1, 32'h300, 1, 32'h304, 0);
        chk("tp3_redirect", 64'(redirect_pc), 64'h300);
        idle(1'b0); idle(1'b0); idle(1'b0);

        // Hold with DEPTH+2 back-to-back offers
        for (int i = 0; i < DEPTH + 2; i++) begin
            cyc(0, 1, 32'h1000 + 32'(i * 4), 1, 32'h2000 + 32'(i), 1, 32'h2000 + 32'(i), 1);
            chk("hold_no_en", 64'(update_en), 64'd0);
        end
        chk("hold_full", 64'(res_ready), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            idle(1'b0);
            chk("drain_order", 64'(update_pc), 64'((32'h1000 + 32'(i * 4)) >> 2));
        end
        idle(1'b0);

        // Reset with 3 entries queued
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h500 + 32'(i * 4), 0, 0, 1, 0, 1);
        cyc(1'b1, 0, 0, 0, 0, 0, 0, 0);
        idle(1'b0); idle(1'b0);
        chk("rst_ready", 64'(res_ready), 64'd1);
        chk("rst_stats", 64'(stat_updates), 64'd0);

        // Accept+pop at DEPTH-1 keeps count steady
        for (int i = 0; i < DEPTH - 1; i++) cyc(0, 1, 32'h600 + 32'(i * 4), 0, 0, 0, 0, 1);
        cyc(0, 1, 32'h700, 0, 0, 0, 0, 0);
        chk("steady_ready", 64'(res_ready), 64'd1);
        cyc(0, 1, 32'h704, 0, 0, 0, 0, 1);
        chk("steady_full", 64'(res_ready), 64'd0);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b0);

        // PC wrap on not-taken redirect
        cyc(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0, 0);
        chk("wrap_redirect", 64'(redirect_pc), 64'h0);

        // Randomized traffic; long enough to saturate 4-bit counters
        for (int i = 0; i < 400; i++) begin
            pc = $urandom() & 32'hFFFF_FFFC;
            tg = $urandom() & 32'hFFFF_FFFC;
            t  = 1'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 30) == 0), 1'($urandom_range(0, 3) != 0), pc, t, tg,
                ($urandom_range(0, 3) == 0) ? ~t : t,
                ($urandom_range(0, 3) == 0) ? tg ^ 32'h10 : tg,
                1'($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 40; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, 1, 32'h40, 0, 32'h40,
                1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_btb_update_queue
`default_nettype wire

// File: doc/btb_update_queue.md
# btb_update_queue

Buffers resolved-branch events from execute and drains them, in order, one per cycle, into the BTB update port (`update_en`/`update_pc`/`actual_taken`/`update_target`). Detects mispredictions at enqueue and issues a registered redirect to the fetch PC logic. Sits between the execute-stage branch unit (upstream) and the BTB write path (downstream). A hold input lets the BTB write path be frozen without losing resolutions.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `CNTW`, 32: statistics counter width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `res_valid` in 1: resolved-branch event offered.
- `res_ready` out 1: queue can accept this cycle.
- `res_pc` in 32: branch PC (word aligned).
- `res_taken` in 1: actual direction.
- `res_target` in 32: actual target.
- `res_pred_taken` in 1: direction predicted at fetch.
- `res_pred_target` in 32: target predicted at fetch.
- `upd_hold` in 1: 1 = do not pop this cycle.
- `update_en` out 1: BTB write strobe.
- `update_pc` out 30: `pc[31:2]` of the drained entry.
- `actual_taken` out 1: direction of the drained entry.
- `update_target` out 32: target of the drained entry.
- `mispredict_valid` out 1: one-cycle redirect pulse.
- `redirect_pc` out 32: correct next fetch PC.
- `stat_updates` out CNTW: BTB writes issued.
- `stat_mispredicts` out CNTW: mispredictions detected.

## Operation
- Accept = `res_valid & res_ready`. The entry {`res_pc[31:2]`, `res_taken`, `res_target`} is written at the tail.
- `res_ready` = `count < DEPTH`. It is derived from registered count only, so a same-cycle pop does not raise it. It is not combinationally dependent on `res_valid`.
- Pop when `count != 0 & ~upd_hold`. The head is copied into the `update_*` output registers, and `update_en` is set for exactly one cycle. If there is no pop, `update_en` = 0 and the other `update_*` outputs hold their last values.
- Simultaneous accept and pop: count is unchanged, and both pointers advance.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Count is `$clog2(DEPTH)+1` bits and ranges 0..DEPTH.
- Misprediction on accept: `res_taken != res_pred_taken`, or `res_taken & (res_target != res_pred_target)`.
  - `mispredict_valid` is registered, high for one cycle.
  - `redirect_pc` = `res_taken ? res_target : res_pc + 4`, 32-bit wrap.
- Non-accepted cycles clear `mispredict_valid`. `redirect_pc` holds its value.
- The queue is never flushed: resolutions are architectural. Only `rst` empties it.
- Reset values: count = 0, pointers = 0, `update_en` = 0, `update_pc` = 0, `actual_taken` = 0, `update_target` = 0, `mispredict_valid` = 0, `redirect_pc` = 0, stats = 0, `res_ready` = 1 in the cycle after reset.
- `rst` asserted mid-operation discards all queued entries and any pending output pulse at that edge.

## Timing
- Accept at edge N produces `mispredict_valid`/`redirect_pc` valid in cycle N+1.
- Accept at edge N into an empty, unheld queue: pop at edge N+1, `update_en` high in cycle N+2.
- Steady-state throughput is one accept and one update per cycle. At full, `res_ready` drops in the cycle after the DEPTH-th accept.
- With `upd_hold` high for k cycles, draining resumes in the cycle after `upd_hold` falls. Order is preserved.

## Configuration
- `BTB_UPD_STATS_EN` defined:
  - `stat_updates` increments on every pop.
  - `stat_mispredicts` increments on every detected misprediction.
  - Both saturate at all-ones and clear on `rst`.
- `BTB_UPD_STATS_EN` undefined: no counter flops. Both stat ports are tied to 0. Ports remain present.

## Structure
- Shared package `btb_pkg`:
  - `btb_upd_entry_t` struct {pc[29:0], taken, target[31:0]}.
  - Localparam `BTB_PC_STEP` = 4.
  - Width constants shared with the BTB.
- Sub-module `btb_upd_fifo`: generic storage, pointers and count, push/pop/full/empty. It is parameterised by DEPTH and entry type.
- The top level holds:
  - the mispredict compare and redirect registers;
  - the `update_*` output registers;
  - the optional counters.

## Test plan
- Reset, then accept pc=0x100, taken=1, target=0x200, matching prediction. Cycle N+2: `update_en`=1, `update_pc`=0x40, `actual_taken`=1, `update_target`=0x200. `mispredict_valid` stays 0.
- Accept pc=0x104, taken=0, pred_taken=1. Cycle N+1: `mispredict_valid`=1, `redirect_pc`=0x108.
- Accept pc=0x10, taken=1, target=0x300, pred target=0x304. Cycle N+1: `mispredict_valid`=1, `redirect_pc`=0x300.
- Hold `upd_hold`=1 and issue DEPTH+2 back-to-back offers.
  - `res_ready` falls after 4 accepts, with no `update_en` during hold.
  - After release, 4 consecutive `update_en` pulses drain in push order.
- Assert `rst` with 3 entries queued. No `update_en` afterwards; `res_ready`=1; stats=0.
- Corner cases:
  - Simultaneous accept+pop at count=DEPTH-1 keeps count steady.
  - pc=0xFFFFFFFC not-taken mispredict gives `redirect_pc`=0x0.
  - With `BTB_UPD_STATS_EN`, forced CNTW=4 counters stop at 15.
